jogador_automatico: RTL and testbench

Hardware auto-player that sits on the far side of the memory-game interface, on the player's end of `circuito_exp6`. It watches the game's `leds`/`vez_jogador` outputs and records each presented one-hot LED value into an internal sequence memory. When the game hands over the turn, it replays the recorded sequence on `botoes` with fixed press/release timing. It is used for on-board self-play and for driving the game from a bench without scripted button values.

---
 rtl/jogador_automatico.sv | 191 +++++++++++++++++++
 tb/tb_jogador_automatico.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: records each one-hot LED value the game presents,
// then replays the recorded sequence on botoes with fixed press/release timing.
module jogador_automatico #(
    parameter int PRESS_CYCLES = 3,
    parameter int GAP_CYCLES   = 2503,
    parameter int DEPTH        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       vez_jogador,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       errar_en,
    input  logic [3:0] errar_indice,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       fim,
    output logic       overflow,
    output logic [3:0] db_estado,
    output logic [4:0] db_contagem
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] CNT_MAX    = 5'(DEPTH);
    localparam logic [11:0] PRESS_LAST = 12'(PRESS_CYCLES - 1);
    localparam logic [11:0] GAP_LAST   = 12'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        CAPTURA   = 4'd1,
        ESPERA    = 4'd2,
        PRESSIONA = 4'd3,
        SOLTA     = 4'd4,
        AGUARDA   = 4'd5,
        FIM       = 4'd6
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [3:0]  leds_ant_q;
    logic        vez_ant_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] tmr_q, tmr_d;
    logic [3:0]  botoes_q, botoes_d;
    logic        ocupado_q, ocupado_d;
    logic        fim_q, fim_d;
    logic        overflow_q, overflow_d;
    logic [3:0]  mem_q [DEPTH];

    logic        evento_cap;
    logic        cap_we;
    logic [3:0]  valor_press;

    function automatic logic um_quente(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] rot_esq(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    assign evento_cap = (estado_q == CAPTURA) && !vez_jogador &&
                        (leds_ant_q == 4'd0) && um_quente(leds);

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        tmr_d      = tmr_q;
        overflow_d = overflow_q;
        cap_we     = 1'b0;

        if (!habilitar) begin
            estado_d = OCIOSO;
            cnt_d    = 5'd0;
        end else if ((ganhou || perdeu) && estado_q != OCIOSO) begin
            estado_d = FIM;
        end else if (!vez_jogador &&
                     (estado_q == ESPERA || estado_q == PRESSIONA || estado_q == SOLTA)) begin
            estado_d = CAPTURA;
            cnt_d    = 5'd0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    cnt_d    = 5'd0;
                    estado_d = CAPTURA;
                end
                CAPTURA: begin
                    if (evento_cap) begin
                        if (cnt_q < CNT_MAX) begin
                            cap_we = 1'b1;
                            cnt_d  = cnt_q + 5'd1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // Use the post-capture count so a same-cycle capture is replayed too.
                    if (vez_jogador && !vez_ant_q && cnt_d != 5'd0) begin
                        estado_d = ESPERA;
                        rd_d     = 5'd0;
                        tmr_d    = 12'd0;
                    end
                end
                ESPERA: begin
                    if (tmr_q == GAP_LAST) begin
                        estado_d = PRESSIONA;
                        tmr_d    = 12'd0;
                    end else begin
                        tmr_d = tmr_q + 12'd1;
                    end
                end
                PRESSIONA: begin
                    if (tmr_q == PRESS_LAST) begin
                        estado_d = SOLTA;
                        rd_d     = rd_q + 5'd1;
                        tmr_d    = 12'd0;
                    end else begin
                        tmr_d = tmr_q + 12'd1;
                    end
                end
                SOLTA: begin
                    if (tmr_q == GAP_LAST) begin
                        tmr_d    = 12'd0;
                        estado_d = (rd_q == cnt_q) ? AGUARDA : PRESSIONA;
                    end else begin
                        tmr_d = tmr_q + 12'd1;
                    end
                end
                AGUARDA: begin
                    if (!vez_jogador) begin
                        estado_d = CAPTURA;
                        cnt_d    = 5'd0;
                    end
                end
                FIM:     estado_d = FIM;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // Outputs are derived from the next state so they change on the same edge as the state.
    always_comb begin
        valor_press = mem_q[rd_d[AW-1:0]];
        if (errar_en && rd_d == {1'b0, errar_indice})
            valor_press = rot_esq(valor_press);
        botoes_d  = (estado_d == PRESSIONA) ? valor_press : 4'd0;
        ocupado_d = (estado_d == ESPERA) || (estado_d == PRESSIONA) || (estado_d == SOLTA);
        fim_d     = (estado_d == FIM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            leds_ant_q <= 4'd0;
            vez_ant_q  <= 1'b0;
            cnt_q      <= 5'd0;
            rd_q       <= 5'd0;
            tmr_q      <= 12'd0;
            botoes_q   <= 4'd0;
            ocupado_q  <= 1'b0;
            fim_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            leds_ant_q <= leds;
            vez_ant_q  <= vez_jogador;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            tmr_q      <= tmr_d;
            botoes_q   <= botoes_d;
            ocupado_q  <= ocupado_d;
            fim_q      <= fim_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (cap_we)
            mem_q[cnt_q[AW-1:0]] <= leds;
    end

    assign botoes      = botoes_q;
    assign ocupado     = ocupado_q;
    assign fim         = fim_q;
    assign overflow    = overflow_q;
    assign db_estado   = 4'(estado_q);
    assign db_contagem = cnt_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: random capture/replay rounds compared against a
// sequence-queue model, plus overflow, game-end, abort and reset scenarios.
module tb_jogador_automatico;

    localparam int P = 3;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0, habilitar = 1'b0, vez = 1'b0, ganhou = 1'b0, perdeu = 1'b0;
    logic       errar_en = 1'b0;
    logic [3:0] errar_indice = 4'd0, leds = 4'd0;
    logic [3:0] botoes, db_estado;
    logic       ocupado, fim, overflow;
    logic [4:0] db_contagem;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the sequence the player has seen this round and the sticky overflow flag.
    logic [3:0] model_seq[$];
    logic       model_ovf;

    jogador_automatico #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .DEPTH(16)) dut (
        .clock(clk), .reset(reset), .habilitar(habilitar), .leds(leds),
        .vez_jogador(vez), .ganhou(ganhou), .perdeu(perdeu), .errar_en(errar_en),
        .errar_indice(errar_indice), .botoes(botoes), .ocupado(ocupado), .fim(fim),
        .overflow(overflow), .db_estado(db_estado), .db_contagem(db_contagem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_onehot(input logic [3:0] v);
        return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
    endfunction

    task automatic do_reset();
        reset = 1'b1; habilitar = 1'b0; vez = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
        leds = 4'd0; errar_en = 1'b0; errar_indice = 4'd0;
        tick(); tick();
        reset = 1'b0;
        model_seq.delete();
        model_ovf = 1'b0;
    endtask

    // Present one LED value for 'hold' cycles followed by 'gap'+1 dark cycles.
    task automatic pulse_led(input logic [3:0] v, input int hold, input int gap);
        leds = v;
        for (int i = 0; i < hold; i++) tick();
        leds = 4'd0;
        for (int i = 0; i <= gap; i++) tick();
        if (is_onehot(v)) begin
            if (model_seq.size() < 16) model_seq.push_back(v);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({botoes, ocupado, fim, overflow, db_estado, db_contagem} !== 15'd0)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {botoes, ocupado, fim, overflow, db_estado, db_contagem});
        else n_pass++;
        habilitar = 1'b1;
        tick();
        n_checks++;
        if (db_estado !== 4'd1) $display("FAIL enable_state: got %0d expected 1", db_estado);
        else n_pass++;
        n_checks++;
        if ({botoes, ocupado, fim, overflow, db_contagem} !== 11'd0)
            $display("FAIL enable_outputs: got %b expected all zero",
                     {botoes, ocupado, fim, overflow, db_contagem});
        else n_pass++;
    endtask

    task automatic test_replay_rounds();
        logic [3:0] expq[$];
        logic [3:0] v;
        int         n;
        do_reset();
        habilitar = 1'b1;
        tick();
        for (int sc = 0; sc < 7; sc++) begin
            errar_en = 1'b0;
            errar_indice = 4'd0;
            if (sc == 0) begin
                pulse_led(4'b0001, 1, 0); pulse_led(4'b0100, 1, 0); pulse_led(4'b1000, 1, 0);
            end else if (sc == 1) begin
                errar_en = 1'b1; errar_indice = 4'd1;
                pulse_led(4'b0001, 1, 0); pulse_led(4'b0100, 1, 0);
            end else begin
                n = $urandom_range(1, 7);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 4) == 0)
                        pulse_led(4'b0011 << $urandom_range(0, 2), 1, $urandom_range(0, 2));
                    pulse_led(4'b0001 << $urandom_range(0, 3), $urandom_range(1, 3),
                              $urandom_range(0, 3));
                end
                errar_en = 1'($urandom_range(0, 1));
                errar_indice = 4'($urandom_range(0, model_seq.size() - 1));
            end
            n_checks++;
            if (db_contagem !== 5'(model_seq.size()))
                $display("FAIL round%0d_count: got %0d expected %0d", sc, db_contagem, model_seq.size());
            else n_pass++;

            expq.delete();
            for (int i = 0; i < G; i++) expq.push_back(4'd0);
            for (int i = 0; i < model_seq.size(); i++) begin
                v = model_seq[i];
                if (errar_en && i == int'(errar_indice)) v = {v[2:0], v[3]};
                for (int k = 0; k < P; k++) expq.push_back(v);
                for (int k = 0; k < G; k++) expq.push_back(4'd0);
            end

            vez = 1'b1;
            for (int c = 0; c < expq.size(); c++) begin
                tick();
                n_checks++;
                if (botoes !== expq[c] || ocupado !== 1'b1)
                    $display("FAIL round%0d_cycle%0d: got botoes=%b ocupado=%b expected botoes=%b ocupado=1",
                             sc, c, botoes, ocupado, expq[c]);
                else n_pass++;
            end
            tick();
            n_checks++;
            if (db_estado !== 4'd5 || botoes !== 4'd0 || ocupado !== 1'b0)
                $display("FAIL round%0d_aguarda: got estado=%0d botoes=%b ocupado=%b expected 5/0000/0",
                         sc, db_estado, botoes, ocupado);
            else n_pass++;
            vez = 1'b0;
            tick();
            model_seq.delete();
            n_checks++;
            if (db_estado !== 4'd1 || db_contagem !== 5'd0)
                $display("FAIL round%0d_recapture: got estado=%0d count=%0d expected 1/0",
                         sc, db_estado, db_contagem);
            else n_pass++;
        end
    endtask

    task automatic test_fim();
        do_reset();
        habilitar = 1'b1;
        tick();
        pulse_led(4'b0010, 1, 0); pulse_led(4'b0001, 1, 0);
        vez = 1'b1;
        for (int i = 0; i < G + 1; i++) tick();
        n_checks++;
        if (botoes !== 4'b0010 || db_estado !== 4'd3)
            $display("FAIL fim_press: got botoes=%b estado=%0d expected 0010/3", botoes, db_estado);
        else n_pass++;
        perdeu = 1'b1;
        tick();
        n_checks++;
        if (botoes !== 4'd0 || fim !== 1'b1 || db_estado !== 4'd6 || ocupado !== 1'b0)
            $display("FAIL fim_enter: got botoes=%b fim=%b estado=%0d ocupado=%b expected 0000/1/6/0",
                     botoes, fim, db_estado, ocupado);
        else n_pass++;
        perdeu = 1'b0;
        vez = 1'b0;
        tick(); tick();
        n_checks++;
        if (db_estado !== 4'd6 || fim !== 1'b1)
            $display("FAIL fim_hold: got estado=%0d fim=%b expected 6/1", db_estado, fim);
        else n_pass++;
        habilitar = 1'b0;
        tick();
        n_checks++;
        if (db_estado !== 4'd0 || fim !== 1'b0 || db_contagem !== 5'd0)
            $display("FAIL fim_exit: got estado=%0d fim=%b count=%0d expected 0/0/0",
                     db_estado, fim, db_contagem);
        else n_pass++;
    endtask

    task automatic test_abort();
        do_reset();
        habilitar = 1'b1;
        tick();
        pulse_led(4'b1000, 1, 0); pulse_led(4'b0100, 1, 0);
        vez = 1'b1;
        for (int i = 0; i < G + P + 1; i++) tick();
        n_checks++;
        if (db_estado !== 4'd4 || botoes !== 4'd0)
            $display("FAIL abort_solta: got estado=%0d botoes=%b expected 4/0000", db_estado, botoes);
        else n_pass++;
        vez = 1'b0;
        tick();
        n_checks++;
        if (db_estado !== 4'd1 || db_contagem !== 5'd0 || botoes !== 4'd0 || ocupado !== 1'b0)
            $display("FAIL abort_result: got estado=%0d count=%0d botoes=%b ocupado=%b expected 1/0/0000/0",
                     db_estado, db_contagem, botoes, ocupado);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [3:0] v;
        do_reset();
        habilitar = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            v = 4'b0001 << $urandom_range(0, 3);
            leds = v;
            tick();
            if (model_seq.size() < 16) model_seq.push_back(v);
            else model_ovf = 1'b1;
            n_checks++;
            if (db_contagem !== 5'(model_seq.size()) || overflow !== model_ovf)
                $display("FAIL ovf_capture%0d: got count=%0d ovf=%b expected %0d/%b",
                         i, db_contagem, overflow, model_seq.size(), model_ovf);
            else n_pass++;
            leds = 4'd0;
            tick();
        end
        pulse_led(4'b0011, 1, 0);
        n_checks++;
        if (db_contagem !== 5'd16 || overflow !== 1'b1)
            $display("FAIL ovf_nononehot: got count=%0d ovf=%b expected 16/1", db_contagem, overflow);
        else n_pass++;
        habilitar = 1'b0;
        tick();
        n_checks++;
        if (db_estado !== 4'd0 || overflow !== 1'b1 || db_contagem !== 5'd0)
            $display("FAIL ovf_sticky: got estado=%0d ovf=%b count=%0d expected 0/1/0",
                     db_estado, overflow, db_contagem);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        habilitar = 1'b1;
        tick();
        model_seq.delete();
        pulse_led(4'b0100, 1, 0); pulse_led(4'b0001, 1, 0);
        vez = 1'b1;
        for (int i = 0; i < G + 2; i++) tick();
        n_checks++;
        if (botoes !== model_seq[0] || overflow !== 1'b1)
            $display("FAIL midreplay_press: got botoes=%b ovf=%b expected %b/1", botoes, overflow, model_seq[0]);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({botoes, ocupado, fim, overflow, db_estado, db_contagem} !== 15'd0)
            $display("FAIL midreplay_reset: got %b expected all zero",
                     {botoes, ocupado, fim, overflow, db_estado, db_contagem});
        else n_pass++;
        reset = 1'b0;
        vez = 1'b0;
    endtask

    initial begin
        test_reset();
        test_replay_rounds();
        test_fim();
        test_abort();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
